// File: rtl/irq_pending_unit.sv
// ---------------------------------------------------------------------------
// irq_pending_unit : 16-channel IRQ edge capture, mask and one-at-a-time offer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module irq_pending_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   input  logic        mask_we,
   input  logic [15:0] mask_din,
   input  logic        ovf_clr,
   input  logic        irq_ready,
   input  logic        eoi,
   output logic [15:0] mask,
   output logic [15:0] pend,
   output logic        irq_valid,
   output logic [3:0]  irq_id,
   output logic        busy,
   output logic [15:0] ovf
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OFFER   = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t      state;
   logic [15:0] req_q;
   logic [15:0] pending;
   logic [15:0] req_edge;
   logic [15:0] clr_vec;
   logic [15:0] ovf_set;
   logic        accept;
   logic [3:0]  win_id;

   assign req_edge = req & ~req_q;
   assign accept   = (state == OFFER) && irq_ready;
   assign clr_vec  = accept ? (16'd1 << irq_id) : 16'd0;
   // A bit being cleared this cycle cannot lose an edge: the edge re-arms it.
   assign ovf_set  = req_edge & pending & ~clr_vec;
   assign pend     = pending & mask;

   // Later (higher) indices overwrite, so bit 15 has top priority.
   always_comb begin
      win_id = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (pend[i]) win_id = 4'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_q   <= req;
         pending <= 16'd0;
         ovf     <= 16'd0;
         mask    <= 16'd0;
      end else begin
         req_q   <= req;
         pending <= (pending & ~clr_vec) | req_edge;
         ovf     <= (ovf_clr ? 16'd0 : ovf) | ovf_set;
         if (mask_we) mask <= mask_din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         irq_id    <= 4'd0;
         irq_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pend != 16'd0) begin
                  irq_id    <= win_id;
                  irq_valid <= 1'b1;
                  state     <= OFFER;
               end
            end
            OFFER: begin
               if (irq_ready) begin
                  irq_valid <= 1'b0;
                  busy      <= 1'b1;
                  state     <= SERVICE;
               end
            end
            SERVICE: begin
               if (eoi) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               irq_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_irq_pending_unit.sv
// ---------------------------------------------------------------------------
// tb_irq_pending_unit : scoreboard bench for irq_pending_unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_irq_pending_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] req;
   logic        mask_we;
   logic [15:0] mask_din;
   logic        ovf_clr;
   logic        irq_ready;
   logic        eoi;
   logic [15:0] mask;
   logic [15:0] pend;
   logic        irq_valid;
   logic [3:0]  irq_id;
   logic        busy;
   logic [15:0] ovf;

   int n_checks = 0;
   int n_pass   = 0;
   logic [3:0] exp_q[$];

   irq_pending_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .mask_we   (mask_we),
      .mask_din  (mask_din),
      .ovf_clr   (ovf_clr),
      .irq_ready (irq_ready),
      .eoi       (eoi),
      .mask      (mask),
      .pend      (pend),
      .irq_valid (irq_valid),
      .irq_id    (irq_id),
      .busy      (busy),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_mask(input logic [15:0] m);
      mask_we  = 1'b1;
      mask_din = m;
      tick();
      mask_we  = 1'b0;
   endtask

   task automatic pulse_req(input logic [15:0] r);
      req = r;
      tick();
      req = 16'd0;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 20 && !irq_valid; i++) tick();
      check("valid_wait", {15'd0, irq_valid}, 16'd1);
   endtask

   task automatic sb_compare();
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL sb_underflow: got offer id %0d expected none", irq_id);
      end else begin
         check("irq_id", {12'd0, irq_id}, {12'd0, exp_q.pop_front()});
      end
   endtask

   task automatic serve();
      wait_valid();
      sb_compare();
      irq_ready = 1'b1;
      tick();
      irq_ready = 1'b0;
      check("accept_busy", {15'd0, busy}, 16'd1);
      check("accept_valid", {15'd0, irq_valid}, 16'd0);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      check("eoi_busy", {15'd0, busy}, 16'd0);
      check("eoi_gap_valid", {15'd0, irq_valid}, 16'd0);
   endtask

   initial begin
      rst_n = 1'b0; req = 16'h0003; mask_we = 1'b0; mask_din = 16'd0;
      ovf_clr = 1'b0; irq_ready = 1'b0; eoi = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check("rst_mask", mask, 16'h0000);
      check("rst_pend", pend, 16'h0000);
      check("rst_ovf", ovf, 16'h0000);
      check("rst_valid", {15'd0, irq_valid}, 16'd0);
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_id", {12'd0, irq_id}, 16'd0);

      // Levels high through reset must not register as edges
      write_mask(16'hFFFF);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("held_level_valid", {15'd0, irq_valid}, 16'd0);
      end
      check("held_level_pend", pend, 16'h0000);
      req = 16'd0;
      tick();

      // Simultaneous edges: higher index first
      pulse_req(16'h0220);
      check("dual_pend", pend, 16'h0220);
      exp_q.push_back(4'd9);
      exp_q.push_back(4'd5);
      serve();
      serve();
      check("dual_done_pend", pend, 16'h0000);

      // Masked channel accumulates, appears on unmask
      write_mask(16'h0000);
      pulse_req(16'h0008);
      tick(); tick();
      check("masked_pend", pend, 16'h0000);
      check("masked_valid", {15'd0, irq_valid}, 16'd0);
      write_mask(16'h0008);
      check("unmask_pend", pend, 16'h0008);
      check("unmask_lat1", {15'd0, irq_valid}, 16'd0);
      tick();
      check("unmask_lat2", {15'd0, irq_valid}, 16'd1);
      exp_q.push_back(4'd3);
      serve();

      // Offer is not retracted by a higher-priority arrival
      write_mask(16'hFFFF);
      pulse_req(16'h0004);
      exp_q.push_back(4'd2);
      exp_q.push_back(4'd14);
      wait_valid();
      pulse_req(16'h4000);
      tick(); tick();
      check("frozen_id", {12'd0, irq_id}, 16'd2);
      check("frozen_valid", {15'd0, irq_valid}, 16'd1);
      check("frozen_pend", pend, 16'h4004);
      serve();
      serve();

      // Lost edge sets overflow, single pending bit
      pulse_req(16'h0080);
      tick();
      pulse_req(16'h0080);
      check("ovf_set", ovf, 16'h0080);
      check("ovf_pend", pend, 16'h0080);
      exp_q.push_back(4'd7);
      serve();
      check("ovf_single_pend", pend, 16'h0000);
      check("ovf_sticky", ovf, 16'h0080);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf_clr", ovf, 16'h0000);

      // Edge coinciding with acceptance of the same channel keeps it pending
      pulse_req(16'h0010);
      exp_q.push_back(4'd4);
      exp_q.push_back(4'd4);
      wait_valid();
      sb_compare();
      irq_ready = 1'b1;
      req = 16'h0010;
      tick();
      irq_ready = 1'b0;
      req = 16'd0;
      check("reedge_pend", pend, 16'h0010);
      check("reedge_busy", {15'd0, busy}, 16'd1);
      check("reedge_no_ovf", ovf, 16'h0000);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      serve();

      // Reset while in service
      pulse_req(16'h0002);
      wait_valid();
      irq_ready = 1'b1;
      tick();
      irq_ready = 1'b0;
      check("pre_rst_busy", {15'd0, busy}, 16'd1);
      pulse_req(16'h0100);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_busy", {15'd0, busy}, 16'd0);
      check("midrst_valid", {15'd0, irq_valid}, 16'd0);
      check("midrst_mask", mask, 16'h0000);
      check("midrst_id", {12'd0, irq_id}, 16'd0);
      write_mask(16'hFFFF);
      check("midrst_pend", pend, 16'h0000);
      tick();
      check("midrst_no_offer", {15'd0, irq_valid}, 16'd0);

      check("sb_leftover", 16'(exp_q.size()), 16'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
